alu_stream_engine: RTL and testbench
====================================

Name: alu_stream_engine

Overview:
Parametrised successor to the team's UART ALU command processor. It parses byte-stream command packets (opcode, reserved byte, 16-bit length, payload of little-endian operands) and folds the operands left-to-right into an accumulator. It streams the accumulator back as OPERAND_BYTES bytes. It sits between the UART's AXI-stream byte ports and an external iterative multiply/divide unit, reached through a valid/ready math port, and adds subtract/remainder modes, partial-operand padding and proper stall-safe TX handshaking.

Parameters:
OPERAND_BYTES, 4, bytes per operand/result; operand width W = 8*OPERAND_BYTES; legal 1..8
LEN_WIDTH, 16, packet length field width; must be 16, two header length bytes

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
rx_data_i  in  8  received byte
rx_valid_i  in  1  received byte valid
rx_ready_o  out  1  engine accepts rx byte; transfer = rx_valid_i & rx_ready_o
tx_data_o  out  8  byte to transmit
tx_valid_o  out  1  tx byte valid
tx_ready_i  in  1  transmitter accepts; transfer = tx_valid_o & tx_ready_i
math_v_o  out  1  math request valid
math_ready_i  in  1  math unit ready for request
math_op_o  out  2  0=MUL, 1=DIV quotient, 2=DIV remainder, 3 unused
math_a_o  out  W  accumulator (dividend / multiplicand), signed
math_b_o  out  W  operand (divisor / multiplier), signed
math_v_i  in  1  math result valid
math_res_i  in  W  math result, low W bits
math_yumi_o  out  1  result consumed
busy_o  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock clk_i. Reset rst_ni is asynchronous, active-low; it clears all state to IDLE, accumulator/operand/counters to 0. All outputs are 0 in reset. Reset mid-packet aborts it. Remaining packet bytes are then parsed as fresh opcodes; unknown values are dropped.
- Packet format: byte0 opcode, byte1 reserved (ignored), byte2 len[7:0], byte3 len[15:8].
  - len = total packet bytes including the 4-byte header. Payload P = len-4. If len<4, treat P=0.
- Opcodes: 0xEC ECHO, 0xAD ADD, 0x5B SUB, 0xAF MUL, 0xF6 DIV, 0xF7 REM. Any other byte in IDLE is consumed and ignored.
- States: IDLE, RSVD, LEN_LO, LEN_HI, LOAD_ACC, LOAD_OPND, EXEC, MATH_REQ, MATH_WAIT, TX, ECHO.
- rx_ready_o: high in IDLE, RSVD, LEN_LO, LEN_HI, LOAD_ACC and LOAD_OPND; low in EXEC, MATH_*, TX. In ECHO, rx_ready_o = tx_ready_i.
- Header path: IDLE -> RSVD -> LEN_LO -> LEN_HI, one state per accepted byte.
  - Accepting byte3 clears acc, operand and byte index, and loads remaining = P.
  - Next state: ECHO if opcode is ECHO and P>0; else IDLE if opcode is ECHO and P=0; else TX if P=0 (result 0); else LOAD_ACC.
- LOAD_ACC / LOAD_OPND:
  - Each accepted byte writes acc/operand[8*idx +: 8], increments idx and decrements remaining.
  - The word completes when idx reaches OPERAND_BYTES-1 or remaining reaches 1. Upper bytes stay 0 (zero-padded partial operand).
  - On completion, LOAD_ACC goes to TX if remaining was 1, else LOAD_OPND. LOAD_OPND goes to EXEC for ADD/SUB, or to MATH_REQ for MUL/DIV/REM.
  - idx resets to 0 on completion; the operand register is cleared on entry to LOAD_OPND.
- EXEC: one cycle. acc = acc + operand (ADD) or acc - operand (SUB), modulo 2^W. Then TX if remaining==0, else LOAD_OPND.
- MATH_REQ: math_v_o=1 with stable math_a_o=acc, math_b_o=operand, math_op_o. Holds until math_ready_i; that cycle moves to MATH_WAIT.
- MATH_WAIT: math_yumi_o = math_v_i. On math_v_i, acc = math_res_i, then TX if remaining==0, else LOAD_OPND. Divide-by-zero result is whatever the unit returns; no timeout.
- TX: tx_valid_o=1, tx_data_o = acc[8*idx +: 8], LSB first.
  - Data and valid are held stable while tx_ready_i=0.
  - idx increments per transfer. After byte OPERAND_BYTES-1 transfers, go to IDLE with idx=0.
- ECHO: tx_data_o = rx_data_i, tx_valid_o = rx_valid_i. Each transfer decrements remaining; on the transfer that makes remaining 0, go to IDLE. No bytes are lost or duplicated under back-pressure on either side.
- No simultaneous rx and tx transfer occurs except in ECHO.

Test Plan:
- ADD, W=32: AD 00 0C 00 | 05 00 00 00 | 03 00 00 00 -> tx 08 00 00 00; busy_o falls the cycle after the last tx transfer.
- SUB with wrap: 5B 00 0C 00 | 01 00 00 00 | 02 00 00 00 -> tx FF FF FF FF.
- MUL chain with model math unit (3-cycle latency, random ready/valid): AF 00 10 00 | -3 | 4 | 5 (32-bit LE) -> tx C4 FF FF FF (-60); exactly 2 math requests observed.
- DIV/REM and partial operand: F6 00 09 00 | 64 00 00 00 | 07 -> tx 0E 00 00 00; same packet with F7 -> tx 02 00 00 00.
- ECHO with random tx_ready_i/rx_valid_i stalls: EC 00 07 00 AA BB CC -> tx AA BB CC exactly once each; next packet parses normally.
- Robustness: garbage byte 0x11 in IDLE ignored. ADD with len=4 -> tx 00 00 00 00. rst_ni pulsed low mid-LOAD_OPND -> all outputs 0 immediately; next packet correct. OPERAND_BYTES=2 run of the ADD case -> tx 08 00.

Source files
------------

// File: rtl/alu_stream_engine.sv
// Byte-stream ALU command engine.
// Parses packets (opcode, reserved, len_lo, len_hi, payload) from the rx byte
// stream and folds little-endian operands left-to-right into an accumulator.
// ADD and SUB are done locally. MUL, DIV and REM go to an external unit.
// The W-bit result is streamed back LSB first, and ECHO forwards its payload
// straight through.
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   rx_data_i/valid_i/ready_o   inbound byte stream
//   tx_data_o/valid_o/ready_i   outbound byte stream
//   math_v_o/ready_i/op_o/a_o/b_o     request to the multiply/divide unit
//   math_v_i/res_i/yumi_o             result from the multiply/divide unit
//   busy_o                      high whenever a packet is in progress
module alu_stream_engine #(
   parameter int unsigned OPERAND_BYTES = 4,
   parameter int unsigned LEN_WIDTH     = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [7:0]                 rx_data_i,
   input  logic                       rx_valid_i,
   output logic                       rx_ready_o,
   output logic [7:0]                 tx_data_o,
   output logic                       tx_valid_o,
   input  logic                       tx_ready_i,
   output logic                       math_v_o,
   input  logic                       math_ready_i,
   output logic [1:0]                 math_op_o,
   output logic [8*OPERAND_BYTES-1:0] math_a_o,
   output logic [8*OPERAND_BYTES-1:0] math_b_o,
   input  logic                       math_v_i,
   input  logic [8*OPERAND_BYTES-1:0] math_res_i,
   output logic                       math_yumi_o,
   output logic                       busy_o
);

   localparam int unsigned W        = 8 * OPERAND_BYTES;
   localparam int unsigned IDX_W    = 3;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OPERAND_BYTES - 1);

   localparam logic [7:0] OP_ECHO = 8'hEC;
   localparam logic [7:0] OP_ADD  = 8'hAD;
   localparam logic [7:0] OP_SUB  = 8'h5B;
   localparam logic [7:0] OP_MUL  = 8'hAF;
   localparam logic [7:0] OP_DIV  = 8'hF6;
   localparam logic [7:0] OP_REM  = 8'hF7;

   typedef enum logic [3:0] {
      S_IDLE, S_RSVD, S_LEN_LO, S_LEN_HI, S_LOAD_ACC, S_LOAD_OPND,
      S_EXEC, S_MATH_REQ, S_MATH_WAIT, S_TX, S_ECHO
   } state_t;

   state_t               state_q, state_d;
   logic [W-1:0]         acc_q, acc_d;
   logic [W-1:0]         opnd_q, opnd_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [LEN_WIDTH-1:0] rem_q, rem_d;
   logic [7:0]           opc_q, opc_d;
   logic [7:0]           len_lo_q, len_lo_d;
   logic                 run_q;
   logic [LEN_WIDTH-1:0] len_w, pay_w;
   logic                 opc_known;
   logic                 opc_local;

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         opnd_q   <= '0;
         idx_q    <= '0;
         rem_q    <= '0;
         opc_q    <= '0;
         len_lo_q <= '0;
         run_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         idx_q    <= idx_d;
         rem_q    <= rem_d;
         opc_q    <= opc_d;
         len_lo_q <= len_lo_d;
         run_q    <= 1'b1;
      end
   end

   // Opcode classification.
   always_comb begin
      opc_known = 1'b0;
      case (rx_data_i)
         OP_ECHO, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_REM: opc_known = 1'b1;
         default: opc_known = 1'b0;
      endcase
      opc_local = (opc_q == OP_ADD) || (opc_q == OP_SUB);
   end

   // Next-state, datapath updates and handshake outputs.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      opnd_d      = opnd_q;
      idx_d       = idx_q;
      rem_d       = rem_q;
      opc_d       = opc_q;
      len_lo_d    = len_lo_q;
      rx_ready_o  = 1'b0;
      tx_valid_o  = 1'b0;
      tx_data_o   = 8'h00;
      math_v_o    = 1'b0;
      math_yumi_o = 1'b0;
      len_w       = LEN_WIDTH'({rx_data_i, len_lo_q});
      // Lengths shorter than the header carry no payload.
      pay_w       = (len_w < LEN_WIDTH'(4)) ? '0 : len_w - LEN_WIDTH'(4);

      case (state_q)
         S_IDLE: begin
            // run_q keeps rx_ready_o low while reset is asserted.
            rx_ready_o = run_q;
            if (rx_valid_i && run_q && opc_known) begin
               opc_d   = rx_data_i;
               state_d = S_RSVD;
            end
         end
         S_RSVD: begin
            rx_ready_o = 1'b1;
            if (rx_valid_i) state_d = S_LEN_LO;
         end
         S_LEN_LO: begin
            rx_ready_o = 1'b1;
            if (rx_valid_i) begin
               len_lo_d = rx_data_i;
               state_d  = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            rx_ready_o = 1'b1;
            if (rx_valid_i) begin
               acc_d  = '0;
               opnd_d = '0;
               idx_d  = '0;
               rem_d  = pay_w;
               if (opc_q == OP_ECHO)
                  state_d = (pay_w == '0) ? S_IDLE : S_ECHO;
               else
                  state_d = (pay_w == '0) ? S_TX : S_LOAD_ACC;
            end
         end
         S_LOAD_ACC: begin
            rx_ready_o = 1'b1;
            if (rx_valid_i) begin
               acc_d[8*idx_q +: 8] = rx_data_i;
               rem_d = rem_q - LEN_WIDTH'(1);
               // A short final word leaves its upper bytes zero.
               if (idx_q == IDX_LAST || rem_q == LEN_WIDTH'(1)) begin
                  idx_d = '0;
                  if (rem_q == LEN_WIDTH'(1)) begin
                     state_d = S_TX;
                  end else begin
                     opnd_d  = '0;
                     state_d = S_LOAD_OPND;
                  end
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_LOAD_OPND: begin
            rx_ready_o = 1'b1;
            if (rx_valid_i) begin
               opnd_d[8*idx_q +: 8] = rx_data_i;
               rem_d = rem_q - LEN_WIDTH'(1);
               if (idx_q == IDX_LAST || rem_q == LEN_WIDTH'(1)) begin
                  idx_d   = '0;
                  state_d = opc_local ? S_EXEC : S_MATH_REQ;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_EXEC: begin
            acc_d = (opc_q == OP_SUB) ? acc_q - opnd_q : acc_q + opnd_q;
            if (rem_q == '0) begin
               state_d = S_TX;
            end else begin
               opnd_d  = '0;
               state_d = S_LOAD_OPND;
            end
         end
         S_MATH_REQ: begin
            math_v_o = 1'b1;
            if (math_ready_i) state_d = S_MATH_WAIT;
         end
         S_MATH_WAIT: begin
            math_yumi_o = math_v_i;
            if (math_v_i) begin
               acc_d = math_res_i;
               if (rem_q == '0) begin
                  state_d = S_TX;
               end else begin
                  opnd_d  = '0;
                  state_d = S_LOAD_OPND;
               end
            end
         end
         S_TX: begin
            tx_valid_o = 1'b1;
            tx_data_o  = acc_q[8*idx_q +: 8];
            if (tx_ready_i) begin
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_ECHO: begin
            // Pass-through: a byte moves only when both sides are ready.
            rx_ready_o = tx_ready_i;
            tx_valid_o = rx_valid_i;
            tx_data_o  = rx_data_i;
            if (rx_valid_i && tx_ready_i) begin
               rem_d = rem_q - LEN_WIDTH'(1);
               if (rem_q == LEN_WIDTH'(1)) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Math request payload taken straight from the working registers.
   assign math_a_o  = acc_q;
   assign math_b_o  = opnd_q;
   assign math_op_o = (opc_q == OP_DIV) ? 2'd1 :
                      (opc_q == OP_REM) ? 2'd2 : 2'd0;
   assign busy_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_stream_engine.sv
// Scoreboard bench for alu_stream_engine: an OPERAND_BYTES=4 instance with a
// randomised-latency math unit model, and an OPERAND_BYTES=2 instance for the
// narrow ADD case. Expected tx bytes are queued when packets are issued.
module tb_alu_stream_engine;

   localparam int unsigned W  = 32;
   localparam int unsigned W2 = 16;

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] rx_data  = 8'h00;
   logic       rx_valid = 1'b0;
   logic       tx_ready = 1'b1;
   logic       sel      = 1'b0;
   logic       stall_en = 1'b0;
   logic       gap_en   = 1'b0;

   logic         math_ready = 1'b0;
   logic         math_v_i   = 1'b0;
   logic [W-1:0] math_res   = '0;

   logic          d1_rx_ready, d1_tx_valid, d1_math_v, d1_math_yumi, d1_busy;
   logic [7:0]    d1_tx_data;
   logic [1:0]    d1_math_op;
   logic [W-1:0]  d1_math_a, d1_math_b;
   logic          d2_rx_ready, d2_tx_valid, d2_math_v, d2_math_yumi, d2_busy;
   logic [7:0]    d2_tx_data;
   logic [1:0]    d2_math_op;
   logic [W2-1:0] d2_math_a, d2_math_b;
   logic [W2-1:0] d2_math_res = '0;
   logic          d2_math_ready = 1'b0;
   logic          d2_math_vi = 1'b0;

   logic d1_rx_valid, d2_rx_valid;
   logic rx_ready, tx_valid, busy;
   logic [7:0] tx_data;

   assign d1_rx_valid = rx_valid & ~sel;
   assign d2_rx_valid = rx_valid &  sel;
   assign rx_ready = sel ? d2_rx_ready : d1_rx_ready;
   assign tx_valid = sel ? d2_tx_valid : d1_tx_valid;
   assign tx_data  = sel ? d2_tx_data  : d1_tx_data;
   assign busy     = sel ? d2_busy     : d1_busy;

   alu_stream_engine #(.OPERAND_BYTES(4), .LEN_WIDTH(16)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .rx_data_i(rx_data), .rx_valid_i(d1_rx_valid), .rx_ready_o(d1_rx_ready),
      .tx_data_o(d1_tx_data), .tx_valid_o(d1_tx_valid), .tx_ready_i(tx_ready),
      .math_v_o(d1_math_v), .math_ready_i(math_ready), .math_op_o(d1_math_op),
      .math_a_o(d1_math_a), .math_b_o(d1_math_b),
      .math_v_i(math_v_i), .math_res_i(math_res), .math_yumi_o(d1_math_yumi),
      .busy_o(d1_busy)
   );

   alu_stream_engine #(.OPERAND_BYTES(2), .LEN_WIDTH(16)) dut2 (
      .clk_i(clk), .rst_ni(rst_ni),
      .rx_data_i(rx_data), .rx_valid_i(d2_rx_valid), .rx_ready_o(d2_rx_ready),
      .tx_data_o(d2_tx_data), .tx_valid_o(d2_tx_valid), .tx_ready_i(tx_ready),
      .math_v_o(d2_math_v), .math_ready_i(d2_math_ready), .math_op_o(d2_math_op),
      .math_a_o(d2_math_a), .math_b_o(d2_math_b),
      .math_v_i(d2_math_vi), .math_res_i(d2_math_res), .math_yumi_o(d2_math_yumi),
      .busy_o(d2_busy)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Tx monitor: pop and compare each transferred byte, check hold under stall.
   logic       hold_pend = 1'b0;
   logic [7:0] hold_data = 8'h00;
   always @(negedge clk) begin
      if (!rst_ni) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            check("tx_hold_valid", 64'(tx_valid), 64'd1);
            check("tx_hold_data", 64'(tx_data), 64'(hold_data));
         end
         hold_pend = 1'b0;
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) check("tx_extra_byte", 64'(exp_q.size()), 64'd1);
            else check("tx_byte", 64'(tx_data), 64'(exp_q.pop_front()));
         end else if (tx_valid) begin
            hold_pend = 1'b1;
            hold_data = tx_data;
         end
      end
   end

   // Random tx back-pressure.
   always @(posedge clk) begin
      #1;
      tx_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   // Math unit model: random ready, 3-cycle latency, random result valid.
   int m_state = 0;
   int m_cnt = 0;
   int math_reqs = 0;
   logic [1:0] m_op = 2'd0;
   logic signed [W-1:0] m_a = '0, m_b = '0;

   function automatic logic [W-1:0] m_calc(input logic [1:0] op,
                                           input logic signed [W-1:0] a,
                                           input logic signed [W-1:0] b);
      case (op)
         2'd0:    return a * b;
         2'd1:    return (b == 0) ? '1 : a / b;
         2'd2:    return (b == 0) ? a : a % b;
         default: return '0;
      endcase
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_ni) begin
            m_state = 0;
         end else begin
            case (m_state)
               0: if (d1_math_v && math_ready) begin
                     m_a = d1_math_a; m_b = d1_math_b; m_op = d1_math_op;
                     math_reqs++; m_cnt = 3; m_state = 1;
                  end
               1: begin m_cnt--; if (m_cnt == 0) m_state = 2; end
               2: if (math_v_i && d1_math_yumi) m_state = 0;
               default: m_state = 0;
            endcase
         end
         @(posedge clk); #1;
         math_ready = (m_state == 0) && ($urandom_range(0, 1) == 1);
         if (m_state == 2) begin
            if (!math_v_i && $urandom_range(0, 1) == 1) begin
               math_v_i = 1'b1;
               math_res = m_calc(m_op, m_a, m_b);
            end
         end else begin
            math_v_i = 1'b0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      if (gap_en) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      rx_data  = b;
      rx_valid = 1'b1;
      do begin @(negedge clk); n++; end while (!rx_ready && n < 500);
      if (!rx_ready) check("rx_accept_timeout", 64'(rx_ready), 64'd1);
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_pkt(input bq_t p);
      foreach (p[i]) send_byte(p[i]);
   endtask

   task automatic push_word(input logic [63:0] w, input int nb);
      for (int i = 0; i < nb; i++) exp_q.push_back(w[8*i +: 8]);
   endtask

   // Wait for the scoreboard to drain, then expect idle on the following cycle.
   task automatic wait_done(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); #2; n++; end
      if (exp_q.size() != 0) begin
         check({tag, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
      if (n > 0) begin @(posedge clk); #1; end
      check({tag, "_busy_fall"}, 64'(busy), 64'd0);
   endtask

   initial begin
      bq_t p;
      logic [31:0] a, b, r;
      logic        is_sub;

      #1;
      check("rst_rx_ready", 64'(d1_rx_ready), 64'd0);
      check("rst_busy", 64'(d1_busy), 64'd0);
      check("rst_tx_valid", 64'(d1_tx_valid), 64'd0);
      check("rst_math_v", 64'(d1_math_v), 64'd0);
      #20;
      @(posedge clk); #1; rst_ni = 1'b1;
      @(posedge clk); #1;

      // ADD 5 + 3
      push_word(64'h8, 4);
      p = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
            8'h03, 8'h00, 8'h00, 8'h00};
      send_pkt(p);
      wait_done("add");

      // Garbage opcode is swallowed without leaving IDLE
      send_byte(8'h11);
      check("garbage_busy", 64'(d1_busy), 64'd0);

      // SUB 1 - 2 wraps
      push_word(64'hFFFF_FFFF, 4);
      p = '{8'h5B, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
            8'h02, 8'h00, 8'h00, 8'h00};
      send_pkt(p);
      wait_done("sub");

      // MUL chain -3 * 4 * 5 under stalls
      stall_en = 1'b1; gap_en = 1'b1; math_reqs = 0;
      push_word(64'hFFFF_FFC4, 4);
      p = '{8'hAF, 8'h00, 8'h10, 8'h00, 8'hFD, 8'hFF, 8'hFF, 8'hFF,
            8'h04, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
      send_pkt(p);
      wait_done("mul");
      check("mul_req_count", 64'(math_reqs), 64'd2);

      // DIV / REM with a one-byte trailing operand
      push_word(64'h0E, 4);
      p = '{8'hF6, 8'h00, 8'h09, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 8'h07};
      send_pkt(p);
      wait_done("div");
      push_word(64'h02, 4);
      p = '{8'hF7, 8'h00, 8'h09, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 8'h07};
      send_pkt(p);
      wait_done("rem");

      // ECHO under stalls on both sides, then a normal packet
      exp_q.push_back(8'hAA); exp_q.push_back(8'hBB); exp_q.push_back(8'hCC);
      p = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'hAA, 8'hBB, 8'hCC};
      send_pkt(p);
      wait_done("echo");
      push_word(64'h8, 4);
      p = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
            8'h03, 8'h00, 8'h00, 8'h00};
      send_pkt(p);
      wait_done("post_echo");

      // Header-only ADD returns zero
      push_word(64'h0, 4);
      p = '{8'hAD, 8'h00, 8'h04, 8'h00};
      send_pkt(p);
      wait_done("add_len4");

      // Reset pulse while loading the second operand
      stall_en = 1'b0; gap_en = 1'b0;
      p = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
      send_pkt(p);
      check("pre_rst_busy", 64'(d1_busy), 64'd1);
      rst_ni = 1'b0;
      #1;
      check("mid_rst_rx_ready", 64'(d1_rx_ready), 64'd0);
      check("mid_rst_busy", 64'(d1_busy), 64'd0);
      check("mid_rst_tx_valid", 64'(d1_tx_valid), 64'd0);
      check("mid_rst_tx_data", 64'(d1_tx_data), 64'd0);
      check("mid_rst_math_v", 64'(d1_math_v), 64'd0);
      check("mid_rst_math_a", 64'(d1_math_a), 64'd0);
      check("mid_rst_math_b", 64'(d1_math_b), 64'd0);
      #10; rst_ni = 1'b1;
      @(posedge clk); #1;
      push_word(64'h8, 4);
      p = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
            8'h03, 8'h00, 8'h00, 8'h00};
      send_pkt(p);
      wait_done("post_rst");

      // Random two-operand ADD/SUB packets
      stall_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         a = $urandom; b = $urandom; is_sub = ($urandom_range(0, 1) == 1);
         r = is_sub ? a - b : a + b;
         push_word(64'(r), 4);
         p = '{};
         p.push_back(is_sub ? 8'h5B : 8'hAD); p.push_back(8'h00);
         p.push_back(8'h0C); p.push_back(8'h00);
         for (int i = 0; i < 4; i++) p.push_back(a[8*i +: 8]);
         for (int i = 0; i < 4; i++) p.push_back(b[8*i +: 8]);
         send_pkt(p);
         wait_done("rand_addsub");
      end

      // Two-byte operand instance
      stall_en = 1'b0;
      sel = 1'b1;
      @(posedge clk); #1;
      push_word(64'h8, 2);
      p = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h05, 8'h00, 8'h03, 8'h00};
      send_pkt(p);
      wait_done("add_ob2");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
